lotr_snapshot_ctrl: RTL and testbench

Synthesizable end-of-test snapshot engine for LOTR. It sequentially reads a fixed shared-data-memory region from each of NUM_TILE gpc tiles and streams every word out on a valid/ready channel. The stream feeds a debug UART/JTAG bridge, so silicon and FPGA runs can dump tile memory without simulator backdoors. A dump starts on a software/host trigger or on a built-in cycle-timeout watchdog.

---
 rtl/lotr_pkg.sv | 29 ++
 rtl/lotr_snapshot_ctrl_if.sv | 36 +++
 rtl/lotr_snapshot_wdog.sv | 33 +++
 rtl/lotr_snapshot_ctrl.sv | 158 +++++++++++++++
 tb/tb_lotr_snapshot_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lotr_pkg.sv
// Shared types and defaults for the LOTR end-of-test snapshot engine.
// Beat fields are sized for the widest supported configuration
// (32-bit data/address, up to 16 tiles); narrower users zero-extend.
package lotr_pkg;

  localparam int SNAP_DATA_W = 32;
  localparam int SNAP_ADDR_W = 32;
  localparam int SNAP_TILE_W = 4;

  localparam logic [SNAP_ADDR_W-1:0] SNAP_REGION_BASE    = 32'h0040_0F00;
  localparam int                     SNAP_REGION_WORDS   = 64;
  localparam int                     SNAP_TIMEOUT_CYCLES = 30000;

  typedef enum logic [2:0] {
    SNAP_IDLE,
    SNAP_REQ,
    SNAP_WAIT,
    SNAP_PUSH,
    SNAP_DONE
  } snap_state_t;

  typedef struct packed {
    logic [SNAP_DATA_W-1:0] data;
    logic [SNAP_ADDR_W-1:0] addr;
    logic [SNAP_TILE_W-1:0] tile;
    logic                   last;
  } snap_beat_t;

endpackage

// File: rtl/lotr_snapshot_ctrl_if.sv
// Memory-read request bus and dump stream of the snapshot engine.
// The master side is the engine; the slave side is the tile memory mux
// plus the debug bridge that sinks the stream.
interface lotr_snapshot_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TILE_W = 1
);

  logic              MemRdEnH;
  logic [TILE_W-1:0] MemRdTile;
  logic [ADDR_W-1:0] MemRdAddr;
  logic [DATA_W-1:0] MemRdData;

  logic              OutValidH;
  logic              OutReadyH;
  logic [DATA_W-1:0] OutData;
  logic [ADDR_W-1:0] OutAddr;
  logic [TILE_W-1:0] OutTile;
  logic              OutLastH;

  modport master (
    output MemRdEnH, MemRdTile, MemRdAddr,
    input  MemRdData,
    output OutValidH, OutData, OutAddr, OutTile, OutLastH,
    input  OutReadyH
  );

  modport slave (
    input  MemRdEnH, MemRdTile, MemRdAddr,
    output MemRdData,
    input  OutValidH, OutData, OutAddr, OutTile, OutLastH,
    output OutReadyH
  );

endinterface

// File: rtl/lotr_snapshot_wdog.sv
// Purpose: idle-cycle watchdog counter with clear and expiry compare.
// Latency: expired is combinational from the registered count.
// Backpressure: none; the owner gates inc and stops counting at expiry.
module lotr_snapshot_wdog
  import lotr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = SNAP_TIMEOUT_CYCLES
) (
  input  logic QClk,
  input  logic RstQnnnL,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Count enabled idle cycles; clear wins over increment.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lotr_snapshot_ctrl.sv
// Purpose: walk a fixed memory region in every tile and stream each word out.
// Latency: read strobe 1 cycle after trigger, first beat 3 cycles after; 1 beat per 3 cycles.
// Backpressure: PUSH holds beat stable until OutReadyH; one read outstanding, no buffering.
module lotr_snapshot_ctrl
  import lotr_pkg::*;
#(
  parameter int                NUM_TILE       = 2,
  parameter int                DATA_W         = SNAP_DATA_W,
  parameter int                ADDR_W         = SNAP_ADDR_W,
  parameter logic [ADDR_W-1:0] REGION_BASE    = SNAP_REGION_BASE,
  parameter int                REGION_WORDS   = SNAP_REGION_WORDS,
  parameter int                TIMEOUT_CYCLES = SNAP_TIMEOUT_CYCLES
) (
  input  logic                 QClk,
  input  logic                 RstQnnnL,
  input  logic                 StartH,
  input  logic                 EnTimeoutH,
  input  logic                 ClrH,
  lotr_snapshot_ctrl_if.master bus,
  output logic                 BusyH,
  output logic                 DoneH,
  output logic                 TimeoutH
);

  localparam int TILE_W = (NUM_TILE > 1) ? $clog2(NUM_TILE) : 1;
  localparam int WORD_W = (REGION_WORDS > 1) ? $clog2(REGION_WORDS) : 1;
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILE - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(REGION_WORDS - 1);

  snap_state_t       state, state_nxt;
  logic [TILE_W-1:0] tile;
  logic [WORD_W-1:0] word;
  logic [ADDR_W-1:0] rd_addr;
  snap_beat_t        hold;
  logic              wdog_inc, wdog_clr, wdog_expired;
  logic              timeout_set, timeout_clr;

  // Byte address wraps naturally at ADDR_W bits.
  assign rd_addr = REGION_BASE + (ADDR_W'(word) << 2);

  lotr_snapshot_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .QClk    (QClk),
    .RstQnnnL(RstQnnnL),
    .inc     (wdog_inc),
    .clr     (wdog_clr),
    .expired (wdog_expired)
  );

  // State register.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      state <= SNAP_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, read strobe, stream valid and watchdog/cause controls.
  always_comb begin
    state_nxt     = state;
    wdog_inc      = 1'b0;
    wdog_clr      = 1'b0;
    timeout_set   = 1'b0;
    timeout_clr   = 1'b0;
    bus.MemRdEnH  = 1'b0;
    bus.MemRdTile = '0;
    bus.MemRdAddr = '0;
    bus.OutValidH = 1'b0;
    bus.OutLastH  = 1'b0;
    case (state)
      SNAP_IDLE: begin
        // Stop counting once expired so the count never passes the limit.
        wdog_inc = EnTimeoutH && !wdog_expired;
        if (StartH) begin
          state_nxt   = SNAP_REQ;
          timeout_clr = 1'b1;
        end else if (EnTimeoutH && wdog_expired) begin
          state_nxt   = SNAP_REQ;
          timeout_set = 1'b1;
        end
      end
      SNAP_REQ: begin
        bus.MemRdEnH  = 1'b1;
        bus.MemRdTile = tile;
        bus.MemRdAddr = rd_addr;
        state_nxt     = SNAP_WAIT;
      end
      SNAP_WAIT: begin
        state_nxt = SNAP_PUSH;
      end
      SNAP_PUSH: begin
        bus.OutValidH = 1'b1;
        bus.OutLastH  = hold.last;
        if (bus.OutReadyH) begin
          state_nxt = hold.last ? SNAP_DONE : SNAP_REQ;
        end
      end
      SNAP_DONE: begin
        if (ClrH) begin
          state_nxt   = SNAP_IDLE;
          wdog_clr    = 1'b1;
          timeout_clr = 1'b1;
        end
      end
      default: state_nxt = SNAP_IDLE;
    endcase
  end

  // Word/tile walk: advance on each accepted non-final beat, rewind in DONE.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      tile <= '0;
      word <= '0;
    end else if (state == SNAP_DONE) begin
      tile <= '0;
      word <= '0;
    end else if (state == SNAP_PUSH && bus.OutReadyH && !hold.last) begin
      if (word == LAST_WORD) begin
        word <= '0;
        tile <= tile + 1'b1;
      end else begin
        word <= word + 1'b1;
      end
    end
  end

  // Capture the returning read word with its origin while in WAIT.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      hold <= '0;
    end else if (state == SNAP_WAIT) begin
      hold.data <= SNAP_DATA_W'(bus.MemRdData);
      hold.addr <= SNAP_ADDR_W'(rd_addr);
      hold.tile <= SNAP_TILE_W'(tile);
      hold.last <= (tile == LAST_TILE) && (word == LAST_WORD);
    end
  end

  // Sticky cause flag: set by watchdog trigger, cleared by StartH or ClrH.
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      TimeoutH <= 1'b0;
    end else if (timeout_set) begin
      TimeoutH <= 1'b1;
    end else if (timeout_clr) begin
      TimeoutH <= 1'b0;
    end
  end

  assign bus.OutData = DATA_W'(hold.data);
  assign bus.OutAddr = ADDR_W'(hold.addr);
  assign bus.OutTile = hold.tile[TILE_W-1:0];
  assign BusyH       = (state == SNAP_REQ) || (state == SNAP_WAIT) || (state == SNAP_PUSH);
  assign DoneH       = (state == SNAP_DONE);

endmodule

// File: tb/tb_lotr_snapshot_ctrl.sv
`timescale 1ns/1ps
module tb_lotr_snapshot_ctrl;
  import lotr_pkg::*;

  localparam int NT = 2;
  localparam int RW = 4;
  localparam int TO = 10;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TW = 1;

  logic QClk = 1'b0;
  logic RstQnnnL = 1'b0;
  logic StartH = 1'b0;
  logic EnTimeoutH = 1'b0;
  logic ClrH = 1'b0;
  logic BusyH, DoneH, TimeoutH;

  lotr_snapshot_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .TILE_W(TW)) bus ();

  lotr_snapshot_ctrl #(
    .NUM_TILE      (NT),
    .DATA_W        (DW),
    .ADDR_W        (AW),
    .REGION_BASE   (32'h0040_0F00),
    .REGION_WORDS  (RW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .QClk      (QClk),
    .RstQnnnL  (RstQnnnL),
    .StartH    (StartH),
    .EnTimeoutH(EnTimeoutH),
    .ClrH      (ClrH),
    .bus       (bus),
    .BusyH     (BusyH),
    .DoneH     (DoneH),
    .TimeoutH  (TimeoutH)
  );

  always #5 QClk = ~QClk;

  // Tile memory: word = {tile, addr[15:0]}, returned one cycle after the strobe.
  always @(posedge QClk) begin
    if (bus.MemRdEnH) bus.MemRdData <= 32'({bus.MemRdTile, bus.MemRdAddr[15:0]});
  end

  int total = 0;
  int bad = 0;
  snap_beat_t exp_q[$];
  snap_beat_t got_q[$];
  int rden_cnt, rden_first, valid_first, stall_err;

  function automatic logic [103:0] all_outs();
    return {bus.MemRdEnH, bus.MemRdTile, bus.MemRdAddr, bus.OutValidH, bus.OutData,
            bus.OutAddr, bus.OutTile, bus.OutLastH, BusyH, DoneH, TimeoutH};
  endfunction

  task automatic push_expected();
    snap_beat_t b;
    logic [31:0] a;
    exp_q.delete();
    for (int t = 0; t < NT; t++) begin
      for (int w = 0; w < RW; w++) begin
        a      = 32'h0040_0F00 + 32'(4 * w);
        b.addr = a;
        b.data = {15'd0, 1'(t), a[15:0]};
        b.tile = 4'(t);
        b.last = (t == NT - 1) && (w == RW - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Drives StartH/OutReadyH for up to budget cycles, recording accepted beats.
  task automatic collect(input bit do_start, input int ready_mode, input bit poke,
                         input int stop_beats, input int budget);
    snap_beat_t cur, prev;
    bit prev_stall;
    int beats;
    got_q.delete();
    rden_cnt = 0; rden_first = -1; valid_first = -1; stall_err = 0;
    prev_stall = 1'b0; beats = 0; prev = '0;
    for (int i = 0; i < budget && beats < stop_beats; i++) begin
      @(negedge QClk);
      StartH        = (do_start && i == 0) || (poke && i > 0 && (i % 2 == 0));
      bus.OutReadyH = (ready_mode == 0) ? 1'b1 : (i % 3 == 2);
      cur.data = bus.OutData;
      cur.addr = bus.OutAddr;
      cur.tile = 4'(bus.OutTile);
      cur.last = bus.OutLastH;
      if (bus.MemRdEnH) begin
        rden_cnt++;
        if (rden_first < 0) rden_first = i;
      end
      if (bus.OutValidH && valid_first < 0) valid_first = i;
      if (prev_stall && (!bus.OutValidH || cur !== prev)) stall_err++;
      prev_stall = bus.OutValidH && !bus.OutReadyH;
      prev = cur;
      if (bus.OutValidH && bus.OutReadyH) begin
        got_q.push_back(cur);
        beats++;
      end
    end
    StartH = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge QClk); ClrH = 1'b1;
    @(negedge QClk); ClrH = 1'b0;
  endtask

  task automatic test_reset();
    RstQnnnL = 1'b0;
    repeat (3) @(negedge QClk);
    total++;
    if (all_outs() !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", all_outs());
    end
    RstQnnnL = 1'b1;
    bus.OutReadyH = 1'b1;
  endtask

  task automatic test_basic();
    snap_beat_t e;
    push_expected();
    collect(1'b1, 0, 1'b0, 8, 100);
    total++;
    if (rden_first !== 1) begin bad++; $display("FAIL basic_rden_latency got=%0d want=1", rden_first); end
    total++;
    if (valid_first !== 3) begin bad++; $display("FAIL basic_valid_latency got=%0d want=3", valid_first); end
    total++;
    if (got_q.size() !== 8) begin bad++; $display("FAIL basic_count got=%0d want=8", got_q.size()); end
    for (int k = 0; k < got_q.size() && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      total++;
      if (got_q[k] !== e) begin bad++; $display("FAIL basic_beat%0d got=%h want=%h", k, got_q[k], e); end
    end
    total++;
    if (rden_cnt !== 8) begin bad++; $display("FAIL basic_reads got=%0d want=8", rden_cnt); end
    @(negedge QClk);
    total++;
    if ({DoneH, BusyH, TimeoutH} !== 3'b100) begin
      bad++; $display("FAIL basic_done done/busy/timeout got=%b want=100", {DoneH, BusyH, TimeoutH});
    end
    do_clear();
    total++;
    if (DoneH !== 1'b0) begin bad++; $display("FAIL basic_clear done got=%b want=0", DoneH); end
  endtask

  task automatic test_backpressure();
    snap_beat_t e;
    push_expected();
    collect(1'b1, 1, 1'b0, 8, 300);
    total++;
    if (got_q.size() !== 8) begin bad++; $display("FAIL bp_count got=%0d want=8", got_q.size()); end
    for (int k = 0; k < got_q.size() && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      total++;
      if (got_q[k] !== e) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", k, got_q[k], e); end
    end
    total++;
    if (stall_err !== 0) begin bad++; $display("FAIL bp_stable unstable_cycles=%0d want=0", stall_err); end
    total++;
    if (rden_cnt !== 8) begin bad++; $display("FAIL bp_reads got=%0d want=8", rden_cnt); end
    bus.OutReadyH = 1'b1;
    @(negedge QClk);
    do_clear();
  endtask

  task automatic test_timeout();
    snap_beat_t e;
    bit early;
    early = 1'b0;
    @(negedge QClk); EnTimeoutH = 1'b1;
    repeat (9) begin
      @(negedge QClk);
      if (bus.MemRdEnH || BusyH) early = 1'b1;
    end
    total++;
    if (early) begin bad++; $display("FAIL wdog_early got=1 want=0"); end
    push_expected();
    collect(1'b0, 0, 1'b0, 8, 100);
    total++;
    if (rden_first !== 0) begin bad++; $display("FAIL wdog_rden_cycle got=%0d want=0", rden_first); end
    total++;
    if (got_q.size() !== 8) begin bad++; $display("FAIL wdog_count got=%0d want=8", got_q.size()); end
    for (int k = 0; k < got_q.size() && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      total++;
      if (got_q[k] !== e) begin bad++; $display("FAIL wdog_beat%0d got=%h want=%h", k, got_q[k], e); end
    end
    @(negedge QClk);
    total++;
    if ({DoneH, TimeoutH} !== 2'b11) begin
      bad++; $display("FAIL wdog_done done/timeout got=%b want=11", {DoneH, TimeoutH});
    end
    EnTimeoutH = 1'b0;
    do_clear();
    total++;
    if ({DoneH, BusyH, TimeoutH} !== 3'b000) begin
      bad++; $display("FAIL wdog_clear done/busy/timeout got=%b want=000", {DoneH, BusyH, TimeoutH});
    end
  endtask

  task automatic test_tie();
    snap_beat_t e;
    @(negedge QClk); EnTimeoutH = 1'b1;
    repeat (8) @(negedge QClk);
    push_expected();
    collect(1'b1, 0, 1'b0, 8, 100);
    total++;
    if (rden_first !== 1) begin bad++; $display("FAIL tie_rden_latency got=%0d want=1", rden_first); end
    total++;
    if (got_q.size() !== 8) begin bad++; $display("FAIL tie_count got=%0d want=8", got_q.size()); end
    for (int k = 0; k < got_q.size() && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      total++;
      if (got_q[k] !== e) begin bad++; $display("FAIL tie_beat%0d got=%h want=%h", k, got_q[k], e); end
    end
    @(negedge QClk);
    total++;
    if ({DoneH, TimeoutH} !== 2'b10) begin
      bad++; $display("FAIL tie_cause done/timeout got=%b want=10", {DoneH, TimeoutH});
    end
    EnTimeoutH = 1'b0;
    do_clear();
  endtask

  task automatic test_async_reset();
    snap_beat_t e;
    bit found;
    push_expected();
    collect(1'b1, 0, 1'b0, 6, 100);
    total++;
    if (got_q.size() !== 6) begin bad++; $display("FAIL arst_pre_count got=%0d want=6", got_q.size()); end
    for (int k = 0; k < got_q.size() && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      total++;
      if (got_q[k] !== e) begin bad++; $display("FAIL arst_pre_beat%0d got=%h want=%h", k, got_q[k], e); end
    end
    @(negedge QClk); bus.OutReadyH = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.OutValidH) found = 1'b1;
      else @(negedge QClk);
    end
    total++;
    if (!found) begin bad++; $display("FAIL arst_wait_push got=no_valid want=valid"); end
    total++;
    if ({bus.OutTile, bus.OutAddr} !== {1'b1, 32'h0040_0F08}) begin
      bad++; $display("FAIL arst_push_beat got=%h want=%h", {bus.OutTile, bus.OutAddr}, {1'b1, 32'h0040_0F08});
    end
    #2 RstQnnnL = 1'b0;
    #1;
    total++;
    if (all_outs() !== '0) begin bad++; $display("FAIL arst_outputs got=%h want=0", all_outs()); end
    @(negedge QClk);
    RstQnnnL = 1'b1;
    bus.OutReadyH = 1'b1;
    push_expected();
    collect(1'b1, 0, 1'b0, 8, 100);
    total++;
    if (got_q.size() !== 8) begin bad++; $display("FAIL arst_post_count got=%0d want=8", got_q.size()); end
    for (int k = 0; k < got_q.size() && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      total++;
      if (got_q[k] !== e) begin bad++; $display("FAIL arst_post_beat%0d got=%h want=%h", k, got_q[k], e); end
    end
    @(negedge QClk);
    do_clear();
  endtask

  task automatic test_ignore_start();
    snap_beat_t e;
    int extra;
    push_expected();
    collect(1'b1, 0, 1'b1, 8, 100);
    total++;
    if (got_q.size() !== 8) begin bad++; $display("FAIL ign_count got=%0d want=8", got_q.size()); end
    for (int k = 0; k < got_q.size() && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      total++;
      if (got_q[k] !== e) begin bad++; $display("FAIL ign_beat%0d got=%h want=%h", k, got_q[k], e); end
    end
    total++;
    if (rden_cnt !== 8) begin bad++; $display("FAIL ign_reads got=%0d want=8", rden_cnt); end
    extra = 0;
    repeat (4) begin
      @(negedge QClk);
      StartH = 1'b1;
      if (bus.MemRdEnH || BusyH) extra++;
    end
    @(negedge QClk);
    StartH = 1'b0;
    total++;
    if ({DoneH, BusyH} !== 2'b10 || extra !== 0) begin
      bad++; $display("FAIL ign_done_hold done/busy got=%b extra=%0d want=10 extra=0", {DoneH, BusyH}, extra);
    end
    do_clear();
    total++;
    if (DoneH !== 1'b0) begin bad++; $display("FAIL ign_clear done got=%b want=0", DoneH); end
  endtask

  initial begin
    bus.OutReadyH = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_tie();
    test_async_reset();
    test_ignore_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim_time=%0t limit=200000", $time);
    $fatal(1);
  end

endmodule
